// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a start bit, then clocks
// out data/parity/stop on device falling edges and checks the device ACK.
module ps2_command_tx #(
  parameter int unsigned CLK_INHIBIT_CYCLES = 5500,
  parameter int unsigned FIRST_EDGE_TIMEOUT = 750000,
  parameter int unsigned XFER_TIMEOUT       = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] the_command,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);

  localparam int unsigned MAX_AB  = (CLK_INHIBIT_CYCLES > FIRST_EDGE_TIMEOUT) ?
                                    CLK_INHIBIT_CYCLES : FIRST_EDGE_TIMEOUT;
  localparam int unsigned MAX_CNT = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
  localparam int          CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] FE_LAST  = CW'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [CW-1:0] XF_LAST  = CW'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_WAIT_EDGE, S_SEND, S_WAIT_ACK, S_WAIT_RELEASE, S_ERROR
  } state_t;

  state_t        state_q;
  logic [1:0]    clkSync_q;
  logic [1:0]    datSync_q;
  logic          clkPrev_q;
  logic [9:0]    shift_q;
  logic [3:0]    bitCnt_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          clkOe_q;
  logic          datOe_q;
  logic          sent_q;
  logic          err_q;
  logic          fallingEdge;
  logic          xferExpired;

  assign fallingEdge = clkPrev_q & ~clkSync_q[1];
  assign xferExpired = (cnt_q == XF_LAST);
  assign cnt_d       = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  assign ps2_clk_oe                    = clkOe_q;
  assign ps2_dat_oe                    = datOe_q;
  assign busy                          = (state_q != S_IDLE);
  assign command_was_sent              = sent_q;
  assign error_communication_timed_out = err_q;

  // Synchronizers reset to the idle-high bus level so leaving reset never looks like a falling edge.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      clkSync_q <= 2'b11;
      datSync_q <= 2'b11;
      clkPrev_q <= 1'b1;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      cnt_q     <= '0;
      clkOe_q   <= 1'b0;
      datOe_q   <= 1'b0;
      sent_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clkSync_q <= {clkSync_q[0], ps2_clk_in};
      datSync_q <= {datSync_q[0], ps2_dat_in};
      clkPrev_q <= clkSync_q[1];
      sent_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clkOe_q <= 1'b0;
          datOe_q <= 1'b0;
          if (send_command) begin
            shift_q  <= {1'b1, ~^the_command, the_command};
            cnt_q    <= '0;
            bitCnt_q <= '0;
            clkOe_q  <= 1'b1;
            state_q  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            datOe_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_START;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_START: begin
          clkOe_q <= 1'b0;
          state_q <= S_WAIT_EDGE;
        end
        S_WAIT_EDGE: begin
          if (fallingEdge) begin
            datOe_q  <= ~shift_q[0];
            shift_q  <= shift_q >> 1;
            bitCnt_q <= 4'd1;
            cnt_q    <= '0;
            state_q  <= S_SEND;
          end else if (cnt_q == FE_LAST) begin
            datOe_q <= 1'b0;
            state_q <= S_ERROR;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_SEND: begin
          if (xferExpired) begin
            datOe_q <= 1'b0;
            state_q <= S_ERROR;
          end else begin
            cnt_q <= cnt_d;
            if (fallingEdge) begin
              datOe_q  <= ~shift_q[0];
              shift_q  <= shift_q >> 1;
              bitCnt_q <= bitCnt_q + 4'd1;
              if (bitCnt_q == 4'd9) begin
                state_q <= S_WAIT_ACK;
              end
            end
          end
        end
        S_WAIT_ACK: begin
          if (xferExpired) begin
            state_q <= S_ERROR;
          end else begin
            cnt_q <= cnt_d;
            if (fallingEdge) begin
              state_q <= datSync_q[1] ? S_ERROR : S_WAIT_RELEASE;
            end
          end
        end
        S_WAIT_RELEASE: begin
          if (xferExpired) begin
            state_q <= S_ERROR;
          end else begin
            cnt_q <= cnt_d;
            if (clkSync_q[1] && datSync_q[1]) begin
              sent_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_ERROR: begin
          clkOe_q <= 1'b0;
          datOe_q <= 1'b0;
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: a device BFM plus a cycle-level model built from the bus protocol rules.
module tb_ps2_command_tx;

  localparam int N   = 8;
  localparam int FET = 100;
  localparam int XT  = 1000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       send = 1'b0;
  logic       bfmClk = 1'b1;
  logic       bfmDat = 1'b1;
  logic       pinClk, pinDat;
  logic       clkOe, datOe, busy, done, err;

  int total = 0;
  int bad = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int hiCnt, datAt, errAt;

  always #10 clk = ~clk;

  assign pinClk = bfmClk & ~clkOe;
  assign pinDat = bfmDat & ~datOe;

  ps2_command_tx #(
    .CLK_INHIBIT_CYCLES(N),
    .FIRST_EDGE_TIMEOUT(FET),
    .XFER_TIMEOUT(XT)
  ) dut (
    .CLOCK_50(clk),
    .resetn(rstn),
    .the_command(cmd),
    .send_command(send),
    .ps2_clk_in(pinClk),
    .ps2_dat_in(pinDat),
    .ps2_clk_oe(clkOe),
    .ps2_dat_oe(datOe),
    .busy(busy),
    .command_was_sent(done),
    .error_communication_timed_out(err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic frameBit(input logic [7:0] c, input int i);
    if (i < 8) return c[i];
    if (i == 8) return (($countones(c) % 2) == 0);
    return 1'b1;
  endfunction

  // Protocol model: expected outputs for the current cycle, stepped once per cycle.
  logic       mBusy = 0, mClk = 0, mDat = 0, mDone = 0, mErr = 0, mErrSt = 0;
  logic [7:0] mCmd = 0;
  int         mT = 0, mEdges = 0, mWc = 0, mXc = 0;
  logic       mS1 = 1, mS2 = 1, mPrev = 1, md1 = 1, md2 = 1;

  task automatic modelReset();
    mBusy = 0; mClk = 0; mDat = 0; mDone = 0; mErr = 0; mErrSt = 0;
    mT = 0; mEdges = 0; mWc = 0; mXc = 0;
    mS1 = 1; mS2 = 1; mPrev = 1; md1 = 1; md2 = 1;
  endtask

  task automatic goErr();
    mClk = 0; mDat = 0; mErrSt = 1;
  endtask

  task automatic modelStep();
    logic fe, cS, dS;
    fe = mPrev & ~mS2;
    cS = mS2;
    dS = md2;
    mDone = 0;
    mErr = 0;
    if (!mBusy) begin
      if (send) begin
        mBusy = 1; mCmd = cmd; mT = 1; mClk = 1; mDat = 0;
        mEdges = 0; mWc = 0; mXc = 0; mErrSt = 0;
      end
    end else if (mErrSt) begin
      mBusy = 0; mErr = 1; mErrSt = 0;
    end else if (mT <= N) begin
      mT++;
      mDat = (mT == N + 1);
    end else if (mT == N + 1) begin
      mT++; mClk = 0; mDat = 1;
    end else if (mEdges == 0) begin
      if (fe) begin
        mEdges = 1;
        mDat = ~frameBit(mCmd, 0);
      end else begin
        mWc++;
        if (mWc == FET) goErr();
      end
    end else begin
      mXc++;
      if (mXc == XT) goErr();
      else if (mEdges < 10) begin
        if (fe) begin
          mDat = ~frameBit(mCmd, mEdges);
          mEdges++;
        end
      end else if (mEdges == 10) begin
        if (fe) begin
          if (!dS) mEdges = 11;
          else goErr();
        end
      end else if (cS && dS) begin
        mBusy = 0; mDone = 1;
      end
    end
    mPrev = mS2; mS2 = mS1; mS1 = pinClk;
    md2 = md1; md1 = pinDat;
  endtask

  always @(negedge clk) begin
    if (!rstn) modelReset();
    checkOutput("outputs{busy,clk_oe,dat_oe,sent,err}", {busy, clkOe, datOe, done, err},
                {mBusy, mClk, mDat, mDone, mErr});
    if (done) doneCnt++;
    if (err) errCnt++;
    if (rstn) modelStep();
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] c);
    cmd = c;
    send = 1'b1;
    cyc();
    send = 1'b0;
  endtask

  task automatic waitIdle(input int maxC);
    int g = 0;
    while (busy && g < maxC) begin
      cyc();
      g++;
    end
    checkOutput("wait_idle", busy, 0);
  endtask

  // Device BFM: waits for the start condition, clocks nEdges falling edges, reads bits on rising edges.
  task automatic bfmFrame(input int halfP, input int nEdges, input bit doAck, output logic [9:0] bits);
    int g = 0;
    bits = '0;
    while (!(clkOe == 1'b0 && datOe == 1'b1) && g < 300) begin
      cyc();
      g++;
    end
    checkOutput("bfm_start_seen", {clkOe, datOe}, 2'b01);
    if (g >= 300) return;
    repeat (halfP) cyc();
    for (int e = 1; e <= nEdges; e++) begin
      if (e == 11 && doAck) begin
        bfmDat = 1'b0;
        repeat (halfP / 2) cyc();
      end
      bfmClk = 1'b0;
      repeat (halfP) cyc();
      bfmClk = 1'b1;
      if (e <= 10) bits[e-1] = pinDat;
      repeat (halfP) cyc();
      if (e == 11) bfmDat = 1'b1;
    end
  endtask

  initial begin
    #(20 * 60000);
    bad++;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [9:0] bits;
    logic [7:0] rc;
    int d0, e0, g, half;
    bit ack;

    repeat (3) cyc();
    checkOutput("reset_outputs", {busy, clkOe, datOe, done, err}, 5'b0);
    rstn = 1'b1;
    repeat (4) cyc();

    d0 = doneCnt; e0 = errCnt;
    applyStimulus(8'hED);
    bfmFrame(20, 11, 1, bits);
    waitIdle(100);
    repeat (3) cyc();
    checkOutput("ed_data", bits[7:0], 8'hED);
    checkOutput("ed_parity", bits[8], 1);
    checkOutput("ed_stop", bits[9], 1);
    checkOutput("ed_sent_pulses", doneCnt - d0, 1);
    checkOutput("ed_err_pulses", errCnt - e0, 0);

    d0 = doneCnt;
    applyStimulus(8'hF4);
    fork
      begin
        hiCnt = 0; datAt = 0;
        for (int i = 1; i <= 20; i++) begin
          @(negedge clk);
          if (clkOe) begin
            hiCnt++;
            if (datOe && datAt == 0) datAt = i;
          end
        end
      end
      bfmFrame(15, 11, 1, bits);
    join
    waitIdle(100);
    repeat (3) cyc();
    checkOutput("f4_clk_oe_cycles", hiCnt, 9);
    checkOutput("f4_dat_oe_rise_cycle", datAt, 9);
    checkOutput("f4_data", bits[7:0], 8'hF4);
    checkOutput("f4_parity", bits[8], 0);
    checkOutput("f4_sent_pulses", doneCnt - d0, 1);

    e0 = errCnt;
    applyStimulus(8'h5A);
    errAt = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (err && errAt == 0) errAt = i;
    end
    cyc();
    checkOutput("first_edge_timeout_cycle", errAt, 111);
    checkOutput("first_edge_timeout_idle", {busy, clkOe, datOe}, 3'b000);
    checkOutput("first_edge_timeout_pulses", errCnt - e0, 1);

    d0 = doneCnt; e0 = errCnt;
    applyStimulus(8'h3C);
    bfmFrame(12, 11, 0, bits);
    waitIdle(100);
    repeat (3) cyc();
    checkOutput("noack_data", bits[7:0], 8'h3C);
    checkOutput("noack_err_pulses", errCnt - e0, 1);
    checkOutput("noack_sent_pulses", doneCnt - d0, 0);

    d0 = doneCnt;
    applyStimulus(8'hED);
    fork
      bfmFrame(18, 11, 1, bits);
      begin
        repeat (80) cyc();
        cmd = 8'h00;
        send = 1'b1;
        cyc();
        send = 1'b0;
      end
    join
    waitIdle(100);
    repeat (20) cyc();
    checkOutput("midframe_data_kept", bits[7:0], 8'hED);
    checkOutput("midframe_sent_pulses", doneCnt - d0, 1);
    checkOutput("midframe_request_dropped", busy, 0);

    d0 = doneCnt; e0 = errCnt;
    applyStimulus(8'h81);
    bfmFrame(10, 5, 0, bits);
    g = 0;
    while (errCnt == e0 && g < 1200) begin
      cyc();
      g++;
    end
    repeat (3) cyc();
    checkOutput("xfer_timeout_err_pulses", errCnt - e0, 1);
    checkOutput("xfer_timeout_sent_pulses", doneCnt - d0, 0);

    applyStimulus(8'hC3);
    fork
      bfmFrame(10, 11, 1, bits);
      begin
        repeat (70) cyc();
        rstn = 1'b0;
        #1;
        checkOutput("reset_async_release", {clkOe, datOe, busy}, 3'b000);
        repeat (3) cyc();
        rstn = 1'b1;
      end
    join
    repeat (5) cyc();
    checkOutput("after_reset_idle", busy, 0);
    d0 = doneCnt;
    applyStimulus(8'hF4);
    bfmFrame(14, 11, 1, bits);
    waitIdle(100);
    repeat (3) cyc();
    checkOutput("after_reset_data", bits[7:0], 8'hF4);
    checkOutput("after_reset_sent_pulses", doneCnt - d0, 1);

    for (int r = 0; r < 5; r++) begin
      rc = 8'($urandom);
      half = $urandom_range(8, 25);
      ack = 1'($urandom_range(0, 1));
      d0 = doneCnt; e0 = errCnt;
      applyStimulus(rc);
      bfmFrame(half, 11, ack, bits);
      waitIdle(200);
      repeat (3) cyc();
      checkOutput("rand_frame", bits, {1'b1, frameBit(rc, 8), rc});
      checkOutput("rand_sent_pulses", doneCnt - d0, ack ? 1 : 0);
      checkOutput("rand_err_pulses", errCnt - e0, ack ? 0 : 1);
      repeat ($urandom_range(1, 10)) cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
